// File: rtl/atlas_bus_pkg.sv
// Shared Atlas-bus constants and the command-and-control word layout.
package atlas_bus_pkg;

   localparam int unsigned CC_WORD_BITS    = 49;
   localparam int unsigned SLOTS_PER_FRAME = 64;
   localparam int unsigned MCLK_PER_CBCLK  = 4;
   localparam int unsigned CNT_BITS        = 8;

   typedef struct packed {
      logic        ptt;
      logic [3:0]  addr;
      logic [31:0] freq_hz;
      logic [3:0]  clock_s;
      logic [6:0]  oc;
      logic        mode;
   } cc_word_t;

endpackage

// File: rtl/atlas_bus_clkgen.sv
// Atlas-bus frame counter with registered CBCLK/CLRCLK and a frame_start strobe at cnt==255.
module atlas_bus_clkgen
   import atlas_bus_pkg::*;
(
   input  logic                CLK_MCLK,
   input  logic                reset,
   output logic [CNT_BITS-1:0] cnt,
   output logic                CBCLK,
   output logic                CLRCLK,
   output logic                frame_start_c
);

   logic [CNT_BITS-1:0] cnt_nxt_c;

   assign cnt_nxt_c     = cnt + CNT_BITS'(1);
   assign frame_start_c = (cnt == {CNT_BITS{1'b1}});

   // Clocks track the next count so they switch on the same edge as cnt.
   always_ff @(posedge CLK_MCLK or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         CBCLK  <= 1'b0;
         CLRCLK <= 1'b0;
      end else begin
         cnt    <= cnt_nxt_c;
         CBCLK  <= cnt_nxt_c[1];
         CLRCLK <= cnt_nxt_c[CNT_BITS-1];
      end
   end

endmodule

// File: rtl/atlas_iq_cc_tx.sv
// Ozy-side Atlas-bus transmitter: serialises I/Q on CDIN and the C&C frame on CC.
// Define ATLAS_IQ_UNDERRUN_CNT_EN to build the saturating underrun counter.
module atlas_iq_cc_tx
   import atlas_bus_pkg::*;
#(
   parameter int unsigned IQ_WIDTH = 16,
   parameter int unsigned CC_PAD   = 10
)
(
   input  logic                    CLK_MCLK,
   input  logic                    reset,
   input  logic [IQ_WIDTH-1:0]     iq_i,
   input  logic [IQ_WIDTH-1:0]     iq_q,
   input  logic                    iq_valid,
   output logic                    iq_ready,
   input  logic [CC_WORD_BITS-1:0] cc_word,
   input  logic                    cc_load,
   output logic                    CBCLK,
   output logic                    CLRCLK,
   output logic                    CDIN,
   output logic                    CDIN_OE,
   output logic                    CC,
   output logic                    iq_underrun,
   output logic [7:0]              iq_underrun_cnt
);

   localparam int unsigned CC_SR_BITS = CC_WORD_BITS + CC_PAD;

   logic [CNT_BITS-1:0]   cnt;
   logic                  frame_start_c;
   logic                  slot_edge_c;
   logic [5:0]            slot_nxt_c;
   logic [4:0]            half_nxt_c;
   logic                  iq_slot_c;
   logic                  cc_slot_c;
   logic                  underrun_c;
   logic                  primed;
   cc_word_t              shadow;
   logic [IQ_WIDTH-1:0]   hold_i;
   logic [IQ_WIDTH-1:0]   hold_q;
   logic [IQ_WIDTH-1:0]   i_sr;
   logic [IQ_WIDTH-1:0]   q_sr;
   logic [CC_SR_BITS-1:0] cc_sr;

   atlas_bus_clkgen u_clkgen (
      .CLK_MCLK      (CLK_MCLK),
      .reset         (reset),
      .cnt           (cnt),
      .CBCLK         (CBCLK),
      .CLRCLK        (CLRCLK),
      .frame_start_c (frame_start_c)
   );

   // Data registers update on the last cycle of a slot, for the slot being entered.
   assign slot_edge_c = (cnt[1:0] == 2'b11);
   assign slot_nxt_c  = cnt[7:2] + 6'd1;
   assign half_nxt_c  = slot_nxt_c[4:0];
   assign iq_slot_c   = (half_nxt_c != 5'd0) && (32'(half_nxt_c) <= IQ_WIDTH);
   assign cc_slot_c   = (slot_nxt_c != 6'd0) && (32'(slot_nxt_c) <= CC_SR_BITS);
   assign underrun_c  = frame_start_c && iq_ready && !iq_valid;

   always_ff @(posedge CLK_MCLK or posedge reset) begin
      if (reset) begin
         primed      <= 1'b0;
         iq_ready    <= 1'b1;
         iq_underrun <= 1'b0;
         shadow      <= '0;
         hold_i      <= '0;
         hold_q      <= '0;
         i_sr        <= '0;
         q_sr        <= '0;
         cc_sr       <= '0;
         CDIN        <= 1'b0;
         CDIN_OE     <= 1'b0;
         CC          <= 1'b0;
      end else begin
         iq_underrun <= underrun_c;
         if (cc_load) begin
            shadow <= cc_word_t'(cc_word);
         end
         // Frame boundary: hold (or a same-cycle sample) moves into the shifters.
         if (frame_start_c) begin
            primed   <= 1'b1;
            iq_ready <= 1'b1;
            cc_sr    <= {shadow, {CC_PAD{1'b0}}};
            if (!iq_ready) begin
               i_sr <= hold_i;
               q_sr <= hold_q;
            end else if (iq_valid) begin
               i_sr <= iq_i;
               q_sr <= iq_q;
            end else begin
               i_sr <= '0;
               q_sr <= '0;
            end
         end else if (iq_valid && iq_ready) begin
            hold_i   <= iq_i;
            hold_q   <= iq_q;
            iq_ready <= 1'b0;
         end
         if (slot_edge_c) begin
            CDIN    <= 1'b0;
            CDIN_OE <= 1'b0;
            CC      <= 1'b0;
            if (primed && iq_slot_c) begin
               CDIN_OE <= 1'b1;
               if (slot_nxt_c[5]) begin
                  CDIN <= q_sr[IQ_WIDTH-1];
                  q_sr <= q_sr << 1;
               end else begin
                  CDIN <= i_sr[IQ_WIDTH-1];
                  i_sr <= i_sr << 1;
               end
            end
            if (cc_slot_c) begin
               CC    <= cc_sr[CC_SR_BITS-1];
               cc_sr <= cc_sr << 1;
            end
         end
      end
   end

`ifdef ATLAS_IQ_UNDERRUN_CNT_EN
   // Saturating count; only reset clears it.
   always_ff @(posedge CLK_MCLK or posedge reset) begin
      if (reset) begin
         iq_underrun_cnt <= 8'd0;
      end else if (underrun_c && (iq_underrun_cnt != 8'hFF)) begin
         iq_underrun_cnt <= iq_underrun_cnt + 8'd1;
      end
   end
`else
   assign iq_underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_atlas_iq_cc_tx.sv
// Directed bench for atlas_iq_cc_tx; expectations come from the frame/slot timing formulas.
module tb_atlas_iq_cc_tx;

   logic        CLK_MCLK = 1'b0;
   logic        reset;
   logic [15:0] iq_i, iq_q;
   logic        iq_valid;
   logic        iq_ready;
   logic [48:0] cc_word;
   logic        cc_load;
   logic        CBCLK, CLRCLK, CDIN, CDIN_OE, CC, iq_underrun;
   logic [7:0]  iq_underrun_cnt;

   int          passed = 0;
   int          total  = 0;
   int          failed = 0;
   logic        rdy;
   int          exp_ucnt;

   localparam logic [48:0] CCA = {1'b1, 4'h0, 32'd22000000, 4'b1010, 7'b1011010, 1'b1};
   localparam logic [48:0] CCB = {1'b0, 4'h5, 32'h0123_4567, 4'h3, 7'h55, 1'b0};

   atlas_iq_cc_tx dut (
      .CLK_MCLK        (CLK_MCLK),
      .reset           (reset),
      .iq_i            (iq_i),
      .iq_q            (iq_q),
      .iq_valid        (iq_valid),
      .iq_ready        (iq_ready),
      .cc_word         (cc_word),
      .cc_load         (cc_load),
      .CBCLK           (CBCLK),
      .CLRCLK          (CLRCLK),
      .CDIN            (CDIN),
      .CDIN_OE         (CDIN_OE),
      .CC              (CC),
      .iq_underrun     (iq_underrun),
      .iq_underrun_cnt (iq_underrun_cnt)
   );

   always #5 CLK_MCLK = ~CLK_MCLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_CBCLK"},   64'(CBCLK),   64'd0);
      chk({tag, "_CLRCLK"},  64'(CLRCLK),  64'd0);
      chk({tag, "_CDIN"},    64'(CDIN),    64'd0);
      chk({tag, "_CDIN_OE"}, 64'(CDIN_OE), 64'd0);
      chk({tag, "_CC"},      64'(CC),      64'd0);
      chk({tag, "_ready"},   64'(iq_ready), 64'd1);
      chk({tag, "_und"},     64'(iq_underrun), 64'd0);
      chk({tag, "_ucnt"},    64'(iq_underrun_cnt), 64'd0);
   endtask

   // Walks one frame from cnt==0 through cnt==last, checking every cycle.
   task automatic run_frame(input logic [15:0] ei, input logic [15:0] eq, input logic eoe,
                            input logic [48:0] ecc, input logic eund,
                            input int offer_at, input logic [15:0] oi, input logic [15:0] oq,
                            input int load_at, input logic [48:0] lcc, input int last);
      logic [58:0] ccb;
      logic [7:0]  kc;
      logic [15:0] w;
      logic        oe_e, cd_e, cc_e;
      int          s, h;
      ccb = {ecc, 10'b0};
      for (int k = 0; k <= last; k++) begin
         kc   = 8'(k);
         s    = k >> 2;
         h    = (k >> 2) & 31;
         w    = kc[7] ? eq : ei;
         oe_e = eoe && (h >= 1) && (h <= 16);
         cd_e = oe_e ? w[16-h] : 1'b0;
         cc_e = (s >= 1 && s <= 59) ? ccb[59-s] : 1'b0;
`ifdef ATLAS_IQ_UNDERRUN_CNT_EN
         if (k == 0 && eund && exp_ucnt != 255) exp_ucnt++;
`endif
         chk("CBCLK",   64'(CBCLK),   64'(kc[1]));
         chk("CLRCLK",  64'(CLRCLK),  64'(kc[7]));
         chk("CDIN_OE", 64'(CDIN_OE), 64'(oe_e));
         chk("CDIN",    64'(CDIN),    64'(cd_e));
         chk("CC",      64'(CC),      64'(cc_e));
         chk("iq_ready", 64'(iq_ready), 64'(rdy));
         chk("iq_underrun", 64'(iq_underrun), 64'((k == 0) && eund));
         chk("ucnt", 64'(iq_underrun_cnt), 64'(exp_ucnt));
         iq_valid = (k == offer_at);
         iq_i     = oi;
         iq_q     = oq;
         cc_load  = (k == load_at);
         cc_word  = lcc;
         @(posedge CLK_MCLK); #1;
         if (k == 255) rdy = 1'b1;
         else if (iq_valid && rdy) rdy = 1'b0;
      end
      iq_valid = 1'b0;
      cc_load  = 1'b0;
   endtask

   initial begin
      reset = 1'b1; iq_i = '0; iq_q = '0; iq_valid = 1'b0; cc_word = '0; cc_load = 1'b0;
      rdy = 1'b1; exp_ucnt = 0;
      repeat (3) @(posedge CLK_MCLK);
      #1;
      chk_reset_vals("rst");
      reset = 1'b0;

      // Frame 1: outputs quiet; preload hold and C&C shadow.
      run_frame(16'h0, 16'h0, 1'b0, 49'h0, 1'b0, 10, 16'hD8F0, 16'h2710, 20, CCA, 255);
      // Frame 2: held sample and C&C word; nothing offered next.
      run_frame(16'hD8F0, 16'h2710, 1'b1, CCA, 1'b0, -1, 16'h0, 16'h0, -1, 49'h0, 255);
      // Frames 3-5: underrun frames with zero data and OE still asserted.
      run_frame(16'h0, 16'h0, 1'b1, CCA, 1'b1, -1, 16'h0, 16'h0, -1, 49'h0, 255);
      run_frame(16'h0, 16'h0, 1'b1, CCA, 1'b1, -1, 16'h0, 16'h0, -1, 49'h0, 255);
      run_frame(16'h0, 16'h0, 1'b1, CCA, 1'b1, 255, 16'h1234, 16'hABCD, 255, CCB, 255);
`ifdef ATLAS_IQ_UNDERRUN_CNT_EN
      chk("ucnt_after_3", 64'(iq_underrun_cnt), 64'd3);
`else
      chk("ucnt_tied", 64'(iq_underrun_cnt), 64'd0);
`endif
      // Frame 6: bypassed sample, old C&C word.
      run_frame(16'h1234, 16'hABCD, 1'b1, CCA, 1'b0, -1, 16'h0, 16'h0, -1, 49'h0, 255);
      // Frame 7: new C&C word, underrun; reset at cnt==100.
      run_frame(16'h0, 16'h0, 1'b1, CCB, 1'b1, -1, 16'h0, 16'h0, -1, 49'h0, 99);
      reset = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge CLK_MCLK);
      @(posedge CLK_MCLK);
      #1;
      chk_reset_vals("midrst_hold");
      reset = 1'b0; rdy = 1'b1; exp_ucnt = 0;
      // Restarted frame: counter from 0, first-frame quiet outputs.
      run_frame(16'h0, 16'h0, 1'b0, 49'h0, 1'b0, -1, 16'h0, 16'h0, -1, 49'h0, 255);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
